// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO drain / UART transmit path.
package fifo_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, wraps, and flags the terminal count.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 868,
    localparam int unsigned CW          = $clog2(CLKS_PER_BIT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    output logic          o_tick_c,
    output logic [CW-1:0] o_cnt
);

    logic [CW-1:0] r_cnt;
    logic          w_terminal;

    assign w_terminal = (r_cnt == CW'(CLKS_PER_BIT - 1));
    assign o_tick_c   = w_terminal && !i_clear;
    assign o_cnt      = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear || w_terminal) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains simple_fifo one word at a time and serialises each word as a start/data/stop
// UART frame, LSB first, with back-to-back frames when more data is waiting.
module fifo_uart_tx
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned CW  = $clog2(CLKS_PER_BIT);
    localparam int unsigned BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    uart_tx_state_t   r_state;
    logic [WIDTH-1:0] r_shift;
    logic [BCW-1:0]   r_bit_cnt;
    logic             r_stop_cnt;
    logic             r_fifo_rd;
    logic             r_tx;
    logic             r_busy;
    logic             r_frame_done;

    logic             w_clear;
    logic             w_tick;
    logic [CW-1:0]    w_baud_cnt;
    logic             w_start;
    logic             w_last_stop_bit;
    logic             w_pre_last;

    assign w_clear         = (r_state == IDLE) || (r_state == POP) || (r_state == LOAD);
    assign w_start         = en && !fifo_empty;
    assign w_last_stop_bit = (r_stop_cnt == 1'(STOP_BITS - 1));
    // frame_done is registered, so it is raised one cycle ahead of the final stop cycle
    assign w_pre_last      = (r_state == STOP) && w_last_stop_bit &&
                             (w_baud_cnt == CW'(CLKS_PER_BIT - 2));

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_clear),
        .o_tick_c (w_tick),
        .o_cnt    (w_baud_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_stop_cnt   <= 1'b0;
            r_fifo_rd    <= 1'b0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_fifo_rd    <= 1'b0;
            r_frame_done <= w_pre_last;
            case (r_state)
                IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (w_start) begin
                        r_fifo_rd <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= POP;
                    end
                end
                POP: begin
                    r_state <= LOAD;
                end
                LOAD: begin
                    r_shift <= fifo_data;
                    r_tx    <= 1'b0;
                    r_state <= START;
                end
                START: begin
                    if (w_tick) begin
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= '0;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bit_cnt == BCW'(WIDTH - 1)) begin
                            r_tx       <= 1'b1;
                            r_stop_cnt <= 1'b0;
                            r_state    <= STOP;
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_cnt <= r_bit_cnt + BCW'(1);
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (w_last_stop_bit) begin
                            // Chain straight into the next pop to avoid an idle gap
                            if (w_start) begin
                                r_fifo_rd <= 1'b1;
                                r_state   <= POP;
                            end else begin
                                r_busy  <= 1'b0;
                                r_state <= IDLE;
                            end
                        end else begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign fifo_rd    = r_fifo_rd;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: two instances (1 and 2 stop bits) fed by 1-cycle-read FIFO models.
module tb_fifo_uart_tx;

    localparam int unsigned CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_a, en_b;
    logic       fe_a = 1'b1, fe_b = 1'b1;
    logic [7:0] fd_a = 8'h00, fd_b = 8'h00;
    logic       rd_a, rd_b, tx_a, tx_b, busy_a, busy_b, done_a, done_b;
    logic       push_a, push_b;
    logic [7:0] pd;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    int         pops_a = 0, pops_b = 0, rd_err_a = 0, rd_err_b = 0;
    int         tests = 0, fails = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .fifo_empty(fe_a), .fifo_data(fd_a),
        .fifo_rd(rd_a), .tx(tx_a), .busy(busy_a), .frame_done(done_a)
    );

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .fifo_empty(fe_b), .fifo_data(fd_b),
        .fifo_rd(rd_b), .tx(tx_b), .busy(busy_b), .frame_done(done_b)
    );

    // FIFO models: pop on fifo_rd, data valid the following cycle
    always @(posedge clk) begin
        if (rd_a) begin
            if (fe_a) rd_err_a <= rd_err_a + 1;
            if (q_a.size() > 0) fd_a <= q_a.pop_front();
            pops_a <= pops_a + 1;
        end
        if (push_a) q_a.push_back(pd);
        fe_a <= (q_a.size() == 0);
    end

    always @(posedge clk) begin
        if (rd_b) begin
            if (fe_b) rd_err_b <= rd_err_b + 1;
            if (q_b.size() > 0) fd_b <= q_b.pop_front();
            pops_b <= pops_b + 1;
        end
        if (push_b) q_b.push_back(pd);
        fe_b <= (q_b.size() == 0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic push(input bit sel, input logic [7:0] d);
        pd = d;
        if (sel) push_b = 1'b1;
        else     push_a = 1'b1;
        @(negedge clk);
        push_a = 1'b0;
        push_b = 1'b0;
    endtask

    // Waits for the start bit, then checks every cycle of the frame and the frame_done pulse
    task automatic expect_frame(input bit sel, input logic [7:0] d, input int nstop,
                                input string name, output int waited);
        int   n;
        bit   found;
        logic t, fd, et, ed;
        n      = (9 + nstop) * CPB;
        waited = 0;
        found  = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            waited++;
            if ((sel ? tx_b : tx_a) === 1'b0) begin
                found = 1;
                break;
            end
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL %s start: tx never fell, got tx=%b required 0", name, sel ? tx_b : tx_a);
            return;
        end
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            t  = sel ? tx_b : tx_a;
            fd = sel ? done_b : done_a;
            if (k < CPB)            et = 1'b0;
            else if (k < 9 * CPB)   et = d[(k - CPB) / CPB];
            else                    et = 1'b1;
            ed = (k == n - 1);
            tests++;
            if (t !== et || fd !== ed) begin
                fails++;
                $display("FAIL %s cycle %0d: tx=%b frame_done=%b required tx=%b frame_done=%b",
                         name, k, t, fd, et, ed);
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (tx_a !== 1'b1 || rd_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 || tx_b !== 1'b1) begin
            fails++;
            $display("FAIL reset_outputs: tx=%b rd=%b busy=%b done=%b tx_b=%b required 1 0 0 0 1",
                     tx_a, rd_a, busy_a, done_a, tx_b);
        end
        @(negedge clk);
        rst  = 1'b0;
        en_a = 1'b1;
        repeat (12) @(negedge clk);
        tests++;
        if (pops_a !== 0 || busy_a !== 1'b0 || tx_a !== 1'b1) begin
            fails++;
            $display("FAIL idle_empty: pops=%0d busy=%b tx=%b required 0 0 1", pops_a, busy_a, tx_a);
        end
    endtask

    task automatic test_single;
        int  p0, w;
        bit  seen;
        p0   = pops_a;
        push(0, 8'hA5);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rd_a === 1'b1) begin
                seen = 1;
                break;
            end
        end
        tests++;
        if (!seen || busy_a !== 1'b1) begin
            fails++;
            $display("FAIL pop_strobe: seen=%0d busy=%b required 1 1", seen, busy_a);
        end
        expect_frame(0, 8'hA5, 1, "frame_a5", w);
        tests++;
        if (w !== 2) begin
            fails++;
            $display("FAIL pop_latency: %0d cycles required 2", w);
        end
        @(negedge clk);
        tests++;
        if (busy_a !== 1'b0 || pops_a - p0 !== 1 || fe_a !== 1'b1 || rd_a !== 1'b0) begin
            fails++;
            $display("FAIL single_end: busy=%b pops=%0d empty=%b rd=%b required 0 1 1 0",
                     busy_a, pops_a - p0, fe_a, rd_a);
        end
    endtask

    task automatic test_back_to_back;
        int p0, w;
        en_a = 1'b0;
        push(0, 8'h01);
        push(0, 8'h02);
        push(0, 8'h03);
        p0   = pops_a;
        en_a = 1'b1;
        expect_frame(0, 8'h01, 1, "b2b_01", w);
        expect_frame(0, 8'h02, 1, "b2b_02", w);
        tests++;
        if (w !== 3) begin
            fails++;
            $display("FAIL b2b_gap_2: %0d cycles from frame_done to start required 3", w);
        end
        expect_frame(0, 8'h03, 1, "b2b_03", w);
        tests++;
        if (w !== 3) begin
            fails++;
            $display("FAIL b2b_gap_3: %0d cycles from frame_done to start required 3", w);
        end
        repeat (10) @(negedge clk);
        tests++;
        if (pops_a - p0 !== 3 || fe_a !== 1'b1 || busy_a !== 1'b0) begin
            fails++;
            $display("FAIL b2b_end: pops=%0d empty=%b busy=%b required 3 1 0",
                     pops_a - p0, fe_a, busy_a);
        end
    endtask

    task automatic test_en_drop;
        int p0, w;
        en_a = 1'b0;
        push(0, 8'h55);
        push(0, 8'h66);
        p0   = pops_a;
        en_a = 1'b1;
        fork
            expect_frame(0, 8'h55, 1, "endrop_55", w);
            begin
                repeat (14) @(negedge clk);
                en_a = 1'b0;
            end
        join
        repeat (8) @(negedge clk);
        tests++;
        if (pops_a - p0 !== 1 || fe_a !== 1'b0 || busy_a !== 1'b0 || tx_a !== 1'b1) begin
            fails++;
            $display("FAIL en_drop: pops=%0d empty=%b busy=%b tx=%b required 1 0 0 1",
                     pops_a - p0, fe_a, busy_a, tx_a);
        end
    endtask

    task automatic test_async_reset;
        int p0, w;
        bit found;
        push(0, 8'hFF);
        p0   = pops_a;
        en_a = 1'b1;
        expect_frame(0, 8'h66, 1, "queued_66", w);
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_a === 1'b0) begin
                found = 1;
                break;
            end
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL ff_start: tx=%b required 0", tx_a);
        end
        repeat (17) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0 || rd_a !== 1'b0 || done_a !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: tx=%b busy=%b rd=%b done=%b required 1 0 0 0",
                     tx_a, busy_a, rd_a, done_a);
        end
        tests++;
        if (pops_a - p0 !== 2) begin
            fails++;
            $display("FAIL reset_pops: %0d required 2", pops_a - p0);
        end
        @(negedge clk);
        push(0, 8'hC3);
        rst = 1'b0;
        expect_frame(0, 8'hC3, 1, "after_reset_c3", w);
        tests++;
        if (w !== 3) begin
            fails++;
            $display("FAIL restart_latency: %0d cycles required 3", w);
        end
    endtask

    task automatic test_two_stop;
        int w;
        en_b = 1'b1;
        push(1, 8'h00);
        expect_frame(1, 8'h00, 2, "two_stop_00", w);
        @(negedge clk);
        tests++;
        if (pops_b !== 1 || busy_b !== 1'b0 || tx_b !== 1'b1) begin
            fails++;
            $display("FAIL two_stop_end: pops=%0d busy=%b tx=%b required 1 0 1", pops_b, busy_b, tx_b);
        end
    endtask

    initial begin
        rst    = 1'b1;
        en_a   = 1'b0;
        en_b   = 1'b0;
        push_a = 1'b0;
        push_b = 1'b0;
        pd     = 8'h00;
        test_reset;
        test_single;
        test_back_to_back;
        test_en_drop;
        test_async_reset;
        test_two_stop;
        tests++;
        if (rd_err_a !== 0 || rd_err_b !== 0) begin
            fails++;
            $display("FAIL pop_when_empty: a=%0d b=%0d required 0 0", rd_err_a, rd_err_b);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
